avalon_multich_accum_slave: RTL and testbench

- Parametrised Avalon-MM slave front-end for the custom function/accumulate accelerator.
- Buffers samples written by the Nios master in a shared FIFO tagged by channel, and streams them to an external pipelined function unit (e.g. CORDIC core) with backpressure.
- Accumulates returned results into NUM_CH independent fixed-point accumulators.
- Stalls accumulator reads via waitrequest until every outstanding sample for that channel has retired.

---
 rtl/avalon_multich_accum_slave.sv | 193 +++++++++++++++++++
 tb/tb_avalon_multich_accum_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multich_accum_slave.sv
// Avalon-MM slave feeding a pipelined function unit from a channel-tagged sample FIFO and
// accumulating returned results per channel; ACC accesses stall until that channel drains.
module avalon_multich_accum_slave #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ACC_W        = 48,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CH_W+1:0] address,
    input  logic            write,
    input  logic [31:0]     writedata,
    input  logic            read,
    output logic [31:0]     readdata,
    output logic            waitrequest,
    output logic            fu_in_valid,
    input  logic            fu_in_ready,
    output logic [31:0]     fu_in_data,
    output logic [CH_W-1:0] fu_in_ch,
    input  logic            fu_out_valid,
    input  logic [31:0]     fu_out_data,
    input  logic [CH_W-1:0] fu_out_ch
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned PEND_W = $clog2(FIFO_DEPTH + MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        RegSample = 2'd0,
        RegAcc    = 2'd1,
        RegStatus = 2'd2,
        RegRsvd   = 2'd3
    } reg_e;

    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [CH_W-1:0]   fifo_ch_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [INF_W-1:0]  inflight_q, inflight_d;
    logic [PEND_W-1:0] pending_q [NUM_CH];
    logic [PEND_W-1:0] pending_d [NUM_CH];
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    reg_e             reg_sel;
    logic [CH_W-1:0]  ch, ret_ch;
    logic             fifo_empty, fifo_full, pop, push;
    logic             sample_wr, acc_wr, rd_en, acc_rd, ch_busy;
    logic [PEND_W-1:0] sel_pending;
    logic [ACC_W-1:0] sel_acc, out_sext, wr_sext;
    logic             sat_pos, sat_neg;
    logic [31:0]      acc_rd_val, status;

    // Mask tags so a channel index can never point past the last accumulator.
    assign ch      = address[CH_W+1:2] & CH_W'(NUM_CH - 1);
    assign ret_ch  = fu_out_ch & CH_W'(NUM_CH - 1);
    assign reg_sel = reg_e'(address[1:0]);

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));

    assign fu_in_valid = !fifo_empty && (inflight_q < INF_W'(MAX_INFLIGHT));
    assign fu_in_data  = fifo_data_q[rd_ptr_q];
    assign fu_in_ch    = fifo_ch_q[rd_ptr_q];
    assign pop         = fu_in_valid && fu_in_ready;

    assign sel_pending = pending_q[ch];
    assign ch_busy     = (sel_pending != '0);
    assign sel_acc     = acc_q[ch];

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign sample_wr = write && (reg_sel == RegSample);
    assign push      = sample_wr && (!fifo_full || pop);
    assign acc_wr    = write && (reg_sel == RegAcc) && !ch_busy;
    assign rd_en     = read && !write;
    assign acc_rd    = rd_en && (reg_sel == RegAcc) && !ch_busy;

    assign waitrequest = (sample_wr && !push)
                       || (write && (reg_sel == RegAcc) && ch_busy)
                       || (rd_en && (reg_sel == RegAcc) && ch_busy);

    assign out_sext = {{(ACC_W - 32){fu_out_data[31]}}, fu_out_data};
    assign wr_sext  = {{(ACC_W - 32){writedata[31]}}, writedata};

    assign sat_pos    = !sel_acc[ACC_W-1] && (|sel_acc[ACC_W-2:31]);
    assign sat_neg    = sel_acc[ACC_W-1] && !(&sel_acc[ACC_W-2:31]);
    assign acc_rd_val = sat_pos ? 32'h7FFF_FFFF : (sat_neg ? 32'h8000_0000 : sel_acc[31:0]);

    always_comb begin
        status        = '0;
        status[0]     = fifo_empty;
        status[1]     = fifo_full;
        status[2]     = ovf_q[ch];
        status[3]     = !ch_busy;
        status[15:8]  = 8'(occ_q);
        status[23:16] = 8'(sel_pending);
    end

    always_comb begin
        readdata = '0;
        if (rd_en) begin
            case (reg_sel)
                RegAcc:    if (!ch_busy) readdata = acc_rd_val;
                RegStatus: readdata = status;
                default:   readdata = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end

        // Stray results must not wrap the counter below zero.
        inflight_d = inflight_q;
        if (pop && !fu_out_valid) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (fu_out_valid && !pop && (inflight_q != '0)) begin
            inflight_d = inflight_q - INF_W'(1);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pending_d[c] = pending_q[c];
            acc_d[c]     = acc_q[c];

            if (push && (ch == CH_W'(c)) && !(fu_out_valid && (ret_ch == CH_W'(c)))) begin
                pending_d[c] = pending_q[c] + PEND_W'(1);
            end else if (fu_out_valid && (ret_ch == CH_W'(c))
                         && !(push && (ch == CH_W'(c))) && (pending_q[c] != '0)) begin
                pending_d[c] = pending_q[c] - PEND_W'(1);
            end

            if (fu_out_valid && (ret_ch == CH_W'(c))) begin
                acc_d[c] = acc_q[c] + out_sext;
            end

            if (acc_wr && (ch == CH_W'(c))) begin
                acc_d[c] = wr_sext;
                ovf_d[c] = 1'b0;
            end else if (acc_rd && (ch == CH_W'(c)) && (sat_pos || sat_neg)) begin
                ovf_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            ovf_q      <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                pending_q[c] <= '0;
                acc_q[c]     <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                pending_q[c] <= pending_d[c];
                acc_q[c]     <= acc_d[c];
            end
        end
    end

    // Sample storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= writedata;
            fifo_ch_q[wr_ptr_q]   <= ch;
        end
    end

endmodule

// File: tb/tb_avalon_multich_accum_slave.sv
// Directed bench: identity function-unit model with runtime latency, scoreboards for issued
// samples and for Avalon read data.
module tb_avalon_multich_accum_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        fu_in_valid;
    logic        fu_in_ready = 1'b1;
    logic [31:0] fu_in_data;
    logic [1:0]  fu_in_ch;
    logic        fu_out_valid = 1'b0;
    logic [31:0] fu_out_data = '0;
    logic [1:0]  fu_out_ch = '0;

    avalon_multich_accum_slave #(
        .NUM_CH       (4),
        .FIFO_DEPTH   (8),
        .ACC_W        (48),
        .MAX_INFLIGHT (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .write        (write),
        .writedata    (writedata),
        .read         (read),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .fu_in_valid  (fu_in_valid),
        .fu_in_ready  (fu_in_ready),
        .fu_in_data   (fu_in_data),
        .fu_in_ch     (fu_in_ch),
        .fu_out_valid (fu_out_valid),
        .fu_out_data  (fu_out_data),
        .fu_out_ch    (fu_out_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] due;
        logic [1:0]  ch;
        logic [31:0] data;
    } fu_item_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_exp_q[$];
    logic [33:0] fu_exp_q[$];
    fu_item_t    fu_pipe[$];
    logic [63:0] cyc = '0;
    int          lat = 3;
    int          issue_cnt = 0;
    int          retire_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Identity function unit; also pops the issue scoreboard.
    always @(posedge clk) begin : fu_model
        fu_item_t    item;
        logic [33:0] e;
        cyc++;
        if (!reset_n) begin
            fu_pipe.delete();
        end else begin
            if (fu_out_valid) retire_cnt++;
            if (fu_in_valid && fu_in_ready) begin
                issue_cnt++;
                if (fu_exp_q.size() == 0) begin
                    timeout_fail("fu_in_unexpected_issue");
                end else begin
                    e = fu_exp_q.pop_front();
                    check("fu_in_data", fu_in_data, e[31:0]);
                    check("fu_in_ch", 32'(fu_in_ch), 32'(e[33:32]));
                end
                fu_pipe.push_back('{due: cyc + 64'(lat), ch: fu_in_ch, data: fu_in_data});
            end
        end
        #1;
        if (reset_n && fu_pipe.size() > 0 && fu_pipe[0].due == cyc + 1) begin
            item         = fu_pipe.pop_front();
            fu_out_valid = 1'b1;
            fu_out_data  = item.data;
            fu_out_ch    = item.ch;
        end else begin
            fu_out_valid = 1'b0;
        end
    end

    task automatic avm_write(input int ch, input int r, input logic [31:0] data,
                             output int stalls);
        @(negedge clk);
        address   = 4'(ch * 4 + r);
        writedata = data;
        write     = 1'b1;
        if (r == 0) fu_exp_q.push_back({2'(ch), data});
        stalls = 0;
        #1;
        while (waitrequest && stalls < 300) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (waitrequest) timeout_fail("write_handshake");
        @(posedge clk);
        #1 write = 1'b0;
    endtask

    task automatic avm_read(input string tag, input int ch, input int r,
                            input logic [31:0] exp, output int stalls);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        address = 4'(ch * 4 + r);
        read    = 1'b1;
        stalls  = 0;
        #1;
        while (waitrequest && stalls < 300) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (waitrequest) begin
            timeout_fail(tag);
            void'(rd_exp_q.pop_front());
        end else begin
            check(tag, readdata, rd_exp_q.pop_front());
        end
        @(posedge clk);
        #1 read = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int st;
        int n;
        int base_i;
        int base_r;
        logic [31:0] vals[4];

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_fu_in_valid", 32'(fu_in_valid), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        avm_read("status_after_reset", 0, 2, 32'h0000_0009, st);
        check("status_no_stall", st, 0);
        avm_read("reserved_reads0", 0, 3, 32'd0, st);
        avm_read("sample_reads0", 0, 0, 32'd0, st);
        avm_write(0, 3, 32'hDEAD_BEEF, st);
        check("reserved_write_no_stall", st, 0);

        // Basic accumulate on ch0
        avm_write(0, 1, 32'd0, st);
        vals = '{32'd5, 32'd10, 32'd15, 32'd20};
        foreach (vals[i]) avm_write(0, 0, vals[i], st);
        avm_read("ch0_sum", 0, 1, 32'd50, st);
        check("ch0_read_stalled", 32'(st > 0), 32'd1);

        // Fill the FIFO with the function unit blocked
        fu_in_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            avm_write(1, 0, 32'(i), st);
            check("fill_no_stall", st, 0);
        end
        avm_read("ch1_status_full", 1, 2, 32'h0008_0802, st);
        @(negedge clk);
        address   = 4'(1 * 4 + 0);
        writedata = 32'd9;
        write     = 1'b1;
        fu_exp_q.push_back({2'd1, 32'd9});
        #1 check("ninth_write_stalls", 32'(waitrequest), 32'd1);
        repeat (3) @(negedge clk);
        #1 check("ninth_write_held", 32'(waitrequest), 32'd1);
        @(negedge clk);
        fu_in_ready = 1'b1;
        #1 check("ninth_write_accepted", 32'(waitrequest), 32'd0);
        @(posedge clk);
        #1 write = 1'b0;
        avm_read("ch1_sum", 1, 1, 32'd45, st);

        // Interleaved ch2 / ch3
        avm_write(2, 0, 32'd1, st);
        avm_write(3, 0, 32'hFFFF_FFFC, st);
        avm_write(2, 0, 32'd2, st);
        avm_write(3, 0, 32'd7, st);
        avm_read("ch2_sum", 2, 1, 32'd3, st);
        avm_read("ch3_sum", 3, 1, 32'd3, st);
        fu_in_ready = 1'b0;
        avm_write(2, 0, 32'd5, st);
        avm_read("ch3_other_pending", 3, 1, 32'd3, st);
        check("ch3_no_stall", st, 0);
        avm_read("ch2_status_pending", 2, 2, 32'h0001_0100, st);
        fu_in_ready = 1'b1;
        avm_read("ch2_sum_after", 2, 1, 32'd8, st);
        check("ch2_read_stalled", 32'(st > 0), 32'd1);

        // Saturation and sticky overflow
        avm_write(1, 1, 32'h7FFF_FFFF, st);
        avm_write(1, 0, 32'd1, st);
        avm_read("ch1_sat_pos", 1, 1, 32'h7FFF_FFFF, st);
        avm_read("ch1_status_ovf", 1, 2, 32'h0000_000D, st);
        avm_write(1, 1, 32'd0, st);
        avm_read("ch1_status_ovf_clr", 1, 2, 32'h0000_0009, st);
        avm_write(1, 1, 32'h8000_0000, st);
        avm_write(1, 0, 32'hFFFF_FFFF, st);
        avm_read("ch1_sat_neg", 1, 1, 32'h8000_0000, st);
        avm_write(1, 0, 32'd5, st);
        avm_write(1, 1, 32'd100, st);
        check("acc_write_stalled", 32'(st > 0), 32'd1);
        avm_read("ch1_acc_written", 1, 1, 32'd100, st);

        // In-flight cap with a slow function unit
        avm_write(0, 1, 32'd0, st);
        fu_in_ready = 1'b0;
        vals = '{32'd100, 32'd200, 32'd300, 32'd400};
        foreach (vals[i]) avm_write(0, 0, vals[i], st);
        lat    = 10;
        base_i = issue_cnt;
        base_r = retire_cnt;
        @(negedge clk);
        fu_in_ready = 1'b1;
        n = 0;
        while (issue_cnt < base_i + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("cap_issue_count", 32'(issue_cnt - base_i), 32'd2);
        check("cap_valid_low", 32'(fu_in_valid), 32'd0);
        repeat (4) @(negedge clk);
        #1 check("cap_valid_held", 32'(fu_in_valid), 32'd0);
        n = 0;
        while (retire_cnt == base_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1 check("resume_after_retire", 32'(fu_in_valid), 32'd1);
        avm_read("ch0_sum_lat10", 0, 1, 32'd1000, st);
        lat = 3;

        // Reset with samples still queued
        fu_in_ready = 1'b0;
        avm_write(0, 0, 32'd1, st);
        avm_write(0, 0, 32'd2, st);
        avm_write(0, 0, 32'd3, st);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_fu_in_valid", 32'(fu_in_valid), 32'd0);
        check("midrst_waitrequest", 32'(waitrequest), 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        fu_exp_q.delete();
        @(negedge clk);
        reset_n     = 1'b1;
        fu_in_ready = 1'b1;
        avm_read("midrst_status", 0, 2, 32'h0000_0009, st);
        avm_read("midrst_acc", 0, 1, 32'd0, st);
        check("midrst_acc_no_stall", st, 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
